bmem_responder: RTL and testbench

- Cycle-accurate burst-memory responder: the memory side of the CPU's bmem interface (bmem_addr/read/write/wdata in; ready/rvalid/raddr/rdata out).
- Lets the cpu top be simulated standalone in Verilator and in unit benches without the external memory model.
- Holds a 64-bit-word backing array, queues outstanding line reads, and returns each read as a 4-beat burst after a fixed latency, in order.
- Flags protocol violations on a sticky error output.

---
 rtl/bmem_if.sv | 21 ++
 rtl/bmem_responder.sv | 161 ++++++++++++++++
 tb/tb_bmem_responder.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bmem_if.sv
// Burst-memory bus between the CPU (master) and the memory responder (slave).
interface bmem_if;
   logic [31:0] bmem_addr;
   logic        bmem_read;
   logic        bmem_write;
   logic [63:0] bmem_wdata;
   logic        bmem_ready;
   logic [31:0] bmem_raddr;
   logic [63:0] bmem_rdata;
   logic        bmem_rvalid;

   modport master (
      output bmem_addr, bmem_read, bmem_write, bmem_wdata,
      input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
   );

   modport slave (
      input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
      output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
   );
endinterface

// File: rtl/bmem_responder.sv
// Burst-memory responder: 64-bit backing store, in-order read queue returning
// 4-beat bursts after a fixed latency, 4-beat write bursts, sticky protocol error.
//
// state   | meaning
// W_IDLE  | no write burst; beat 0 may be accepted
// W_BEAT1 | expecting write beat 1 (same addr, write high)
// W_BEAT2 | expecting write beat 2
// W_BEAT3 | expecting write beat 3
// R_IDLE  | no response beat this cycle
// R_BEAT0 | driving beat 0 of the queue head
// R_BEAT1 | driving beat 1
// R_BEAT2 | driving beat 2
// R_BEAT3 | driving beat 3; head pops at the end of this cycle
module bmem_responder #(
   parameter int LATENCY   = 4,
   parameter int QDEPTH    = 4,
   parameter int MEM_WORDS = 1024
) (
   input  logic   clk,
   input  logic   rst,
   bmem_if.slave  bus,
   output logic   error
);
   localparam int AW = $clog2(MEM_WORDS);
   localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CW = $clog2(QDEPTH + 1);
   localparam int GW = $clog2(LATENCY + 1);
   localparam logic [GW-1:0] AGE_MAX = GW'(LATENCY);
   // Ages are register values one cycle behind acceptance, so the head is due
   // for its first beat once its age reaches LATENCY-2.
   localparam logic [GW-1:0] AGE_DUE = GW'(LATENCY - 2);

   typedef enum logic [1:0] {W_IDLE, W_BEAT1, W_BEAT2, W_BEAT3} w_state_t;
   typedef enum logic [2:0] {R_IDLE, R_BEAT0, R_BEAT1, R_BEAT2, R_BEAT3} r_state_t;

   logic [63:0]   mem    [MEM_WORDS];
   logic [31:0]   addr_q [QDEPTH];
   logic [GW-1:0] age_q  [QDEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr, nxt_ptr;
   logic [CW-1:0] count, count_next;
   w_state_t      w_state, w_next;
   r_state_t      r_state, r_next;
   logic [31:0]   w_addr;
   logic [1:0]    w_beat;
   logic [1:0]    beat_k;
   logic [31:0]   beat_addr;
   logic [AW-1:0] wr_idx, rd_idx;
   logic [63:0]   rdata_next;
   logic          accept_rd, accept_wr, beat_ok, wr_en;
   logic          push, pop, head_due, next_due, ready_next, violation;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign w_beat  = w_state;
   assign nxt_ptr = ptr_inc(rd_ptr);

   always_comb begin
      accept_rd = bus.bmem_ready && bus.bmem_read && !bus.bmem_write;
      accept_wr = bus.bmem_ready && bus.bmem_write && !bus.bmem_read;
      beat_ok   = (w_state != W_IDLE) && bus.bmem_write && (bus.bmem_addr == w_addr);
      wr_en     = accept_wr || beat_ok;
      if (w_state == W_IDLE)
         wr_idx = bus.bmem_addr[3 +: AW];
      else
         wr_idx = w_addr[3 +: AW] + AW'(w_beat);

      w_next = W_IDLE;
      case (w_state)
         W_IDLE:  w_next = accept_wr ? W_BEAT1 : W_IDLE;
         W_BEAT1: w_next = beat_ok ? W_BEAT2 : W_IDLE;
         W_BEAT2: w_next = beat_ok ? W_BEAT3 : W_IDLE;
         default: w_next = W_IDLE;
      endcase

      head_due  = (count != '0) && (age_q[rd_ptr] >= AGE_DUE);
      next_due  = (count > CW'(1)) && (age_q[nxt_ptr] >= AGE_DUE);
      r_next    = R_IDLE;
      pop       = 1'b0;
      beat_addr = addr_q[rd_ptr];
      beat_k    = 2'd0;
      case (r_state)
         R_IDLE:  r_next = head_due ? R_BEAT0 : R_IDLE;
         R_BEAT0: begin r_next = R_BEAT1; beat_k = 2'd1; end
         R_BEAT1: begin r_next = R_BEAT2; beat_k = 2'd2; end
         R_BEAT2: begin r_next = R_BEAT3; beat_k = 2'd3; end
         default: begin
            pop = 1'b1;
            if (next_due) begin
               r_next    = R_BEAT0;
               beat_addr = addr_q[nxt_ptr];
            end
         end
      endcase

      // A write landing on the same edge is forwarded so the beat sees it.
      rd_idx     = beat_addr[3 +: AW] + AW'(beat_k);
      rdata_next = (wr_en && (wr_idx == rd_idx)) ? bus.bmem_wdata : mem[rd_idx];

      push       = accept_rd;
      count_next = count + CW'(push) - CW'(pop);
      ready_next = (count_next != CW'(QDEPTH)) && (w_next == W_IDLE);

      violation = (bus.bmem_read && bus.bmem_write)
               || ((accept_rd || accept_wr) && (bus.bmem_addr[4:0] != 5'd0))
               || ((bus.bmem_read || bus.bmem_write) && !bus.bmem_ready && (w_state == W_IDLE))
               || ((w_state != W_IDLE) && !beat_ok);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_state         <= W_IDLE;
         r_state         <= R_IDLE;
         rd_ptr          <= '0;
         wr_ptr          <= '0;
         count           <= '0;
         w_addr          <= '0;
         bus.bmem_ready  <= 1'b0;
         bus.bmem_rvalid <= 1'b0;
         bus.bmem_raddr  <= '0;
         bus.bmem_rdata  <= '0;
         error           <= 1'b0;
         for (int i = 0; i < QDEPTH; i++) begin
            addr_q[i] <= '0;
            age_q[i]  <= '0;
         end
      end else begin
         w_state <= w_next;
         r_state <= r_next;
         if ((w_state == W_IDLE) && accept_wr)
            w_addr <= bus.bmem_addr;
         if (push) begin
            addr_q[wr_ptr] <= bus.bmem_addr;
            wr_ptr         <= ptr_inc(wr_ptr);
         end
         if (pop)
            rd_ptr <= nxt_ptr;
         for (int i = 0; i < QDEPTH; i++) begin
            if (push && (wr_ptr == PW'(i)))
               age_q[i] <= '0;
            else if (age_q[i] != AGE_MAX)
               age_q[i] <= age_q[i] + GW'(1);
         end
         count           <= count_next;
         bus.bmem_ready  <= ready_next;
         bus.bmem_rvalid <= (r_next != R_IDLE);
         if (r_next != R_IDLE) begin
            bus.bmem_raddr <= beat_addr;
            bus.bmem_rdata <= rdata_next;
         end
         error <= error | violation;
      end
   end

   // Backing store is deliberately left out of reset so contents survive it.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_idx] <= bus.bmem_wdata;
   end
endmodule

// File: tb/tb_bmem_responder.sv
// Bench for bmem_responder: directed table, corner sequences and random traffic
// checked against a transaction-level model of the memory and read schedule.
module tb_bmem_responder;
   localparam int LAT = 4;
   localparam int QD  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic error;

   bmem_if bus();

   bmem_responder #(.LATENCY(LAT), .QDEPTH(QD), .MEM_WORDS(1024)) dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus),
      .error (error)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: memory image, scheduled read bursts, write-burst progress, error flag.
   typedef struct {
      logic [31:0] addr;
      int          start;
   } rd_t;

   logic [63:0] mem_m [0:1023];
   rd_t         q[$];
   int          cyc;
   int          last_end;
   bit          wr_active;
   int          wr_beat;
   logic [31:0] wr_addr;
   bit          err_m;
   bit          rst_cycle;
   bit          exp_ready;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] a;
      logic [63:0] d;
      logic        e_ready;
      logic        e_rvalid;
      logic [31:0] e_raddr;
      logic [63:0] e_rdata;
   } vec_t;

   vec_t tbl [19];

   function automatic vec_t mkv(logic rd, logic wr, logic [31:0] a, logic [63:0] d,
                                logic er, logic ev, logic [31:0] ea, logic [63:0] ed);
      vec_t v;
      v.rd = rd; v.wr = wr; v.a = a; v.d = d;
      v.e_ready = er; v.e_rvalid = ev; v.e_raddr = ea; v.e_rdata = ed;
      return v;
   endfunction

   function automatic int widx(logic [31:0] a, int k);
      return (int'(a[12:3]) + k) % 1024;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic prep();
      while (q.size() > 0 && q[0].start + 3 < cyc)
         void'(q.pop_front());
      exp_ready = !rst_cycle && !wr_active && (q.size() < QD);
   endtask

   task automatic model_check();
      prep();
      chk("ready", 64'(bus.bmem_ready), 64'(exp_ready));
      chk("error", 64'(error), 64'(err_m));
      if (q.size() > 0 && q[0].start <= cyc) begin
         chk("rvalid", 64'(bus.bmem_rvalid), 64'd1);
         chk("raddr", 64'(bus.bmem_raddr), 64'(q[0].addr));
         chk("rdata", bus.bmem_rdata, mem_m[widx(q[0].addr, cyc - q[0].start)]);
      end else begin
         chk("rvalid", 64'(bus.bmem_rvalid), 64'd0);
      end
   endtask

   task automatic model_update(input logic rd, input logic wr,
                               input logic [31:0] a, input logic [63:0] d);
      if (rd && wr) err_m = 1'b1;
      if (wr_active) begin
         if (wr && a == wr_addr) begin
            mem_m[widx(wr_addr, wr_beat)] = d;
            wr_beat++;
            if (wr_beat == 4) wr_active = 1'b0;
         end else begin
            err_m     = 1'b1;
            wr_active = 1'b0;
         end
      end else if ((rd || wr) && !exp_ready) begin
         err_m = 1'b1;
      end else if (exp_ready && (rd ^ wr)) begin
         if (a[4:0] != 5'd0) err_m = 1'b1;
         if (rd) begin
            int s;
            s = (cyc + LAT > last_end + 1) ? cyc + LAT : last_end + 1;
            q.push_back('{addr: a, start: s});
            last_end = s + 3;
         end else begin
            mem_m[widx(a, 0)] = d;
            wr_active = 1'b1;
            wr_beat   = 1;
            wr_addr   = a;
         end
      end
      rst_cycle = 1'b0;
   endtask

   // Entered and left at a negedge: check this cycle, drive, clock, advance model.
   task automatic step(input logic rd, input logic wr,
                       input logic [31:0] a, input logic [63:0] d);
      model_check();
      bus.bmem_read  = rd;
      bus.bmem_write = wr;
      bus.bmem_addr  = a;
      bus.bmem_wdata = d;
      @(posedge clk);
      model_update(rd, wr, a, d);
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 32'h0, 64'h0);
   endtask

   task automatic do_reset();
      #1 rst = 1'b1;
      #1;
      chk("rst_rvalid", 64'(bus.bmem_rvalid), 64'd0);
      chk("rst_ready", 64'(bus.bmem_ready), 64'd0);
      bus.bmem_read  = 1'b0;
      bus.bmem_write = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      q.delete();
      wr_active = 1'b0;
      err_m     = 1'b0;
      last_end  = -100;
      cyc       = -1;
      rst_cycle = 1'b1;
      idle(1);
   endtask

   initial begin
      bus.bmem_read  = 1'b0;
      bus.bmem_write = 1'b0;
      bus.bmem_addr  = '0;
      bus.bmem_wdata = '0;
      cyc = 0;

      for (int i = 0; i < 19; i++)
         tbl[i] = mkv(1'b0, 1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 32'h0, 64'h0);
      tbl[0]  = mkv(1'b0, 1'b1, 32'h40, 64'h11, 1'b1, 1'b0, 32'h0, 64'h0);
      tbl[1]  = mkv(1'b0, 1'b1, 32'h40, 64'h22, 1'b0, 1'b0, 32'h0, 64'h0);
      tbl[2]  = mkv(1'b0, 1'b1, 32'h40, 64'h33, 1'b0, 1'b0, 32'h0, 64'h0);
      tbl[3]  = mkv(1'b0, 1'b1, 32'h40, 64'h44, 1'b0, 1'b0, 32'h0, 64'h0);
      tbl[10] = mkv(1'b1, 1'b0, 32'h40, 64'h0, 1'b1, 1'b0, 32'h0, 64'h0);
      tbl[14] = mkv(1'b0, 1'b0, 32'h0, 64'h0, 1'b1, 1'b1, 32'h40, 64'h11);
      tbl[15] = mkv(1'b0, 1'b0, 32'h0, 64'h0, 1'b1, 1'b1, 32'h40, 64'h22);
      tbl[16] = mkv(1'b0, 1'b0, 32'h0, 64'h0, 1'b1, 1'b1, 32'h40, 64'h33);
      tbl[17] = mkv(1'b0, 1'b0, 32'h0, 64'h0, 1'b1, 1'b1, 32'h40, 64'h44);

      @(negedge clk);
      do_reset();

      // Write 0x40 then read it back at cycle 10.
      for (int i = 0; i < 19; i++) begin
         chk("tbl_ready", 64'(bus.bmem_ready), 64'(tbl[i].e_ready));
         chk("tbl_rvalid", 64'(bus.bmem_rvalid), 64'(tbl[i].e_rvalid));
         if (tbl[i].e_rvalid) begin
            chk("tbl_raddr", 64'(bus.bmem_raddr), 64'(tbl[i].e_raddr));
            chk("tbl_rdata", bus.bmem_rdata, tbl[i].e_rdata);
         end
         chk("tbl_error", 64'(error), 64'd0);
         step(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d);
      end

      // Preload lines 0..15 with random data.
      for (int line = 0; line < 16; line++)
         for (int k = 0; k < 4; k++)
            step(1'b0, 1'b1, 32'(line * 32), {$urandom(), $urandom()});
      idle(2);

      // Fill the queue, then a read while full.
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'(i * 32), 64'h0);
      for (int c = 4; c <= 20; c++) begin
         if (c == 4) begin
            chk("full_ready", 64'(bus.bmem_ready), 64'd0);
            step(1'b1, 1'b0, 32'h80, 64'h0);
         end else begin
            if (c == 8) chk("refill_ready", 64'(bus.bmem_ready), 64'd1);
            idle(1);
         end
      end
      chk("full_error", 64'(error), 64'd1);

      // Read and write together: no change, no response.
      do_reset();
      step(1'b1, 1'b1, 32'h80, 64'hDEAD_BEEF_0000_0001);
      idle(8);
      chk("rw_error", 64'(error), 64'd1);
      step(1'b1, 1'b0, 32'h80, 64'h0);
      idle(8);

      // Write burst dropped at beat 2.
      do_reset();
      step(1'b0, 1'b1, 32'h100, 64'hA0A0_0000_0000_0001);
      step(1'b0, 1'b1, 32'h100, 64'hA0A0_0000_0000_0002);
      step(1'b0, 1'b0, 32'h100, 64'h0);
      chk("abort_ready", 64'(bus.bmem_ready), 64'd1);
      chk("abort_error", 64'(error), 64'd1);
      step(1'b1, 1'b0, 32'h100, 64'h0);
      idle(8);

      // Reset during beat 1 with two reads queued.
      do_reset();
      step(1'b1, 1'b0, 32'h00, 64'h0);
      step(1'b1, 1'b0, 32'h20, 64'h0);
      idle(3);
      chk("pre_rst_rvalid", 64'(bus.bmem_rvalid), 64'd1);
      do_reset();
      idle(6);
      step(1'b1, 1'b0, 32'h00, 64'h0);
      step(1'b1, 1'b0, 32'h20, 64'h0);
      idle(10);

      // Random traffic over the preloaded lines.
      do_reset();
      for (int n = 0; n < 500; n++) begin
         int r;
         prep();
         r = int'($urandom_range(0, 9));
         if (wr_active)
            step(1'b0, 1'b1, wr_addr, {$urandom(), $urandom()});
         else if (exp_ready && r < 3)
            step(1'b1, 1'b0, 32'($urandom_range(0, 15) * 32), 64'h0);
         else if (exp_ready && r == 3)
            step(1'b0, 1'b1, 32'($urandom_range(0, 15) * 32), {$urandom(), $urandom()});
         else
            idle(1);
      end
      idle(30);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
